memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  SEQ Y86-64 memory stage: sits directly downstream of execute, consuming valE/valA/valP/icode.
//  Holds byte-addressable little-endian data memory; performs 8-byte loads/stores per icode.
//  Produces valM for writeback and the instruction status (stat).
//  Keeps a sticky halt latch that blocks all stores once a non-AOK status has retired.
// PARAMETERS
//  DEPTH  1024  data memory size in bytes; legal 8-byte access address range 0..DEPTH-8
//  AW     64    address/data width; fixed at 64, not to be overridden
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  icode        in   4   instruction code from fetch
//  instr_valid  in   1   fetch decoded a legal icode/ifun
//  imem_error   in   1   fetch address out of range
//  valE         in   64  execute result (address for rmmovq/mrmovq/call/pushq)
//  valA         in   64  store data (rmmovq/pushq); address for ret/popq
//  valP         in   64  return address stored by call
//  valM         out  64  load data; 0 when icode does no read or on dmem_error
//  dmem_error   out  1   current access address > DEPTH-8
//  stat         out  3   1=AOK 2=HLT 3=ADR 4=INS
//  halted       out  1   sticky: a non-AOK stat has been clocked
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all memory bytes <= 0, halted <= 0; rst beats any store that cycle.
//  - Access decode (combinational):
//    rmmovq 4: write M[valE]=valA | mrmovq 5: read M[valE]
//    call 8:   write M[valE]=valP | ret 9:    read M[valA]
//    pushq A:  write M[valE]=valA | popq B:   read M[valA]
//    all other icodes: no access, dmem_error=0, valM=0.
//  - Address check: unsigned 64-bit compare addr > DEPTH-8 -> dmem_error=1 (no wrap; 0xFFFF..F8 errors).
//  - Read: combinational, zero latency; valM = {M[a+7],...,M[a]} (little-endian).
//  - Write: at posedge, bytes a..a+7 <= data[7:0]..data[63:56]; visible to reads the next cycle.
//  - Write suppressed when dmem_error, halted=1, rst=1, or stat!=AOK.
//  - stat priority: imem_error->ADR(3); else !instr_valid->INS(4); else icode==0->HLT(2);
//    else dmem_error->ADR(3); else AOK(1). While halted=1, stat holds the value latched at the halt.
//  - Halt FSM: RUN --(posedge, stat!=AOK)--> HALT; HALT --rst--> RUN; no other exit.
//    In HALT: no writes; valM still reflects combinational reads (debug visibility).
//  - stat/valM/dmem_error are combinational from inputs; no registered outputs except halted & latched stat.
// CONFIGURATION
//  MEM_STATS_EN defined: adds outputs rd_count[31:0], wr_count[31:0]; increment at posedge on each
//   committed read (no dmem_error, not halted) / committed write; saturate at 0xFFFFFFFF; cleared by rst.
//  MEM_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 rst, then rmmovq valE=16 valA=0x1122334455667788; next cycle mrmovq valE=16 -> valM=0x1122334455667788, stat=1.
//  2 after 1, mrmovq valE=17 -> valM=0x0011223344556677 (unaligned, little-endian), dmem_error=0.
//  3 pushq valE=DEPTH-8 valA=5 -> written; pushq valE=DEPTH-7 -> dmem_error=1, stat=3, halted=1 next edge, no write.
//  4 halted=1, rmmovq valE=0 valA=9 -> M[0] unchanged; assert rst -> halted=0, mrmovq valE=16 -> valM=0.
//  5 call valE=100 valP=0x40, then ret valA=100 -> valM=0x40; icode=0 -> stat=2, halted=1 next edge.
//  6 MEM_STATS_EN: 2 writes + 3 reads (one erroring, which halts) -> wr_count=2, rd_count=2; rst -> both 0.

Source files
------------

// File: rtl/memory_stage.sv
// SEQ Y86-64 memory stage: byte-addressed little-endian data memory, stat generation and sticky halt.
// Optional MEM_STATS_EN adds committed read/write counters (rd_count, wr_count).
module memory_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 64  // fixed at 64; address/data width of the Y86-64 datapath
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    icode,
  input  logic          instr_valid,
  input  logic          imem_error,
  input  logic [AW-1:0] valE,
  input  logic [AW-1:0] valA,
  input  logic [AW-1:0] valP,
  output logic [AW-1:0] valM,
  output logic          dmem_error,
  output logic [2:0]    stat,
  output logic          halted
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 8);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [7:0]    mem [DEPTH];
  logic          is_rd, is_wr;
  logic [AW-1:0] addr, wdata, rdata;
  logic [IW-1:0] aidx;
  logic [2:0]    stat_now, stat_q;
  logic [0:0]    state;
  logic          wr_en;

  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    addr  = valE;
    wdata = valA;
    case (icode)
      I_RMMOVQ: is_wr = 1'b1;
      I_MRMOVQ: is_rd = 1'b1;
      I_CALL: begin
        is_wr = 1'b1;
        wdata = valP;
      end
      I_RET, I_POPQ: begin
        is_rd = 1'b1;
        addr  = valA;
      end
      I_PUSHQ: is_wr = 1'b1;
      default: ;
    endcase
  end

  // Full-width unsigned compare so addresses near 2^64 never wrap into range.
  assign dmem_error = (is_rd || is_wr) && (addr > MAX_ADDR);
  assign aidx       = addr[IW-1:0];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++)
      rdata[8*i +: 8] = mem[aidx + IW'(i)];
  end

  assign valM = (is_rd && !dmem_error) ? rdata : '0;

  always_comb begin
    if (imem_error)         stat_now = S_ADR;
    else if (!instr_valid)  stat_now = S_INS;
    else if (icode == I_HALT) stat_now = S_HLT;
    else if (dmem_error)    stat_now = S_ADR;
    else                    stat_now = S_AOK;
  end

  assign halted = (state == ST_HALT);
  assign stat   = halted ? stat_q : stat_now;
  assign wr_en  = is_wr && !dmem_error && !halted && !rst && (stat_now == S_AOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else if (wr_en) begin
      for (int i = 0; i < 8; i++)
        mem[aidx + IW'(i)] <= wdata[8*i +: 8];
    end
  end

  // Halt latch: the first non-AOK status is captured and held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      stat_q <= S_AOK;
    end else if (state == ST_RUN && stat_now != S_AOK) begin
      state  <= ST_HALT;
      stat_q <= stat_now;
    end
  end

`ifdef MEM_STATS_EN
  logic rd_commit;
  assign rd_commit = is_rd && !dmem_error && !halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_commit && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      if (wr_en && wr_count != 32'hFFFF_FFFF)     wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized traffic against a byte-array model.
module tb_memory_stage;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst, instr_valid, imem_error;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP, valM;
  logic        dmem_error, halted;
  logic [2:0]  stat;
`ifdef MEM_STATS_EN
  logic [31:0] rd_count, wr_count;
`endif

  memory_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .valE(valE), .valA(valA), .valP(valP),
    .valM(valM), .dmem_error(dmem_error), .stat(stat), .halted(halted)
`ifdef MEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0]  mm [DEPTH];
  logic        m_halt;
  logic [2:0]  m_hold;
  logic [31:0] m_rd, m_wr;
  logic        e_rd, e_wr, e_derr;
  logic [63:0] e_addr, e_data, e_valM;
  logic [2:0]  e_now, e_stat;

  function automatic logic [63:0] mread(input logic [63:0] a);
    logic [63:0] r;
    int base;
    base = int'(a[15:0]);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mm[base + i];
    return r;
  endfunction

  task automatic model_eval();
    e_rd   = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
    e_wr   = (icode == 4'h4) || (icode == 4'h8) || (icode == 4'hA);
    e_addr = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
    e_data = (icode == 4'h8) ? valP : valA;
    e_derr = (e_rd || e_wr) && (e_addr > 64'(DEPTH - 8));
    e_valM = (e_rd && !e_derr) ? mread(e_addr) : 64'd0;
    if (imem_error)          e_now = 3'd3;
    else if (!instr_valid)   e_now = 3'd4;
    else if (icode == 4'h0)  e_now = 3'd2;
    else if (e_derr)         e_now = 3'd3;
    else                     e_now = 3'd1;
    e_stat = m_halt ? m_hold : e_now;
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
      m_halt = 1'b0;
      m_hold = 3'd1;
      m_rd = 0;
      m_wr = 0;
    end else begin
      if (e_rd && !e_derr && !m_halt && m_rd != 32'hFFFF_FFFF) m_rd++;
      if (e_wr && !m_halt && e_now == 3'd1) begin
        for (int i = 0; i < 8; i++) mm[int'(e_addr[15:0]) + i] = e_data[8*i +: 8];
        if (m_wr != 32'hFFFF_FFFF) m_wr++;
      end
      if (!m_halt && e_now != 3'd1) begin
        m_halt = 1'b1;
        m_hold = e_now;
      end
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] ic, input logic v, input logic ie,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    @(negedge clk);
    rst = r; icode = ic; instr_valid = v; imem_error = ie;
    valE = e; valA = a; valP = p;
    #1;
    model_eval();
    chk("valM", valM, e_valM);
    chk("dmem_error", 64'(dmem_error), 64'(e_derr));
    chk("stat", 64'(stat), 64'(e_stat));
    chk("halted", 64'(halted), 64'(m_halt));
`ifdef MEM_STATS_EN
    chk("rd_count", 64'(rd_count), 64'(m_rd));
    chk("wr_count", 64'(wr_count), 64'(m_wr));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 4'h1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    tick();
  endtask

  function automatic logic [63:0] rand_addr();
    int k;
    k = $urandom_range(0, 19);
    if (k < 16)       return 64'($urandom_range(0, 56));
    else if (k < 18)  return 64'($urandom_range(DEPTH - 12, DEPTH - 1));
    else if (k == 18) return 64'hFFFF_FFFF_FFFF_FFF8;
    else              return {$urandom, $urandom};
  endfunction

  initial begin
    logic [3:0] ops [6];
    logic [3:0] ic;
    logic       r, v, ie;
    int         k;
    ops = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    rst = 1'b1; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
    valE = '0; valA = '0; valP = '0;
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'hxx;
    m_halt = 1'b0; m_hold = 3'd1; m_rd = 0; m_wr = 0;

    do_reset();
    chk("reset_halted", 64'(halted), 64'd0);

    // store then aligned and unaligned loads
    apply(1'b0, 4'h4, 1'b1, 1'b0, 64'd16, 64'h1122334455667788, 64'd0);
    chk("t1_stat", 64'(stat), 64'd1);
    tick();
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'd16, 64'd0, 64'd0);
    chk("t1_valM", valM, 64'h1122334455667788);
    tick();
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'd17, 64'd0, 64'd0);
    chk("t2_valM", valM, 64'h0011223344556677);
    chk("t2_derr", 64'(dmem_error), 64'd0);
    tick();

    // top-of-memory boundary, then one byte past it
    apply(1'b0, 4'hA, 1'b1, 1'b0, 64'(DEPTH - 8), 64'd5, 64'd0);
    tick();
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'(DEPTH - 8), 64'd0, 64'd0);
    chk("t3_edge_valM", valM, 64'd5);
    tick();
    apply(1'b0, 4'hA, 1'b1, 1'b0, 64'(DEPTH - 7), 64'd7, 64'd0);
    chk("t3_derr", 64'(dmem_error), 64'd1);
    chk("t3_stat", 64'(stat), 64'd3);
    tick();
    chk("t3_halted", 64'(halted), 64'd1);
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'(DEPTH - 8), 64'd0, 64'd0);
    chk("t3_nowrite", valM, 64'd5);
    tick();

    // halted: stores blocked, reads still visible; reset releases
    apply(1'b0, 4'h4, 1'b1, 1'b0, 64'd0, 64'd9, 64'd0);
    tick();
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    chk("t4_m0", valM, 64'd0);
    chk("t4_stat_held", 64'(stat), 64'd3);
    tick();
    do_reset();
    chk("t4_rst_halted", 64'(halted), 64'd0);
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'd16, 64'd0, 64'd0);
    chk("t4_cleared", valM, 64'd0);
    chk("t4_stat", 64'(stat), 64'd1);
    tick();

    // call/ret round trip, then halt instruction
    apply(1'b0, 4'h8, 1'b1, 1'b0, 64'd100, 64'd0, 64'h40);
    tick();
    apply(1'b0, 4'h9, 1'b1, 1'b0, 64'd0, 64'd100, 64'd0);
    chk("t5_ret", valM, 64'h40);
    tick();
    apply(1'b0, 4'h0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    chk("t5_hlt", 64'(stat), 64'd2);
    tick();
    chk("t5_halted", 64'(halted), 64'd1);
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0);
    chk("t5_stat_held", 64'(stat), 64'd2);
    chk("t5_nowrap_derr", 64'(dmem_error), 64'd1);
    tick();

`ifdef MEM_STATS_EN
    do_reset();
    apply(1'b0, 4'h4, 1'b1, 1'b0, 64'd0, 64'd1, 64'd0); tick();
    apply(1'b0, 4'hA, 1'b1, 1'b0, 64'd8, 64'd2, 64'd0); tick();
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0); tick();
    apply(1'b0, 4'hB, 1'b1, 1'b0, 64'd0, 64'd8, 64'd0); tick();
    apply(1'b0, 4'h5, 1'b1, 1'b0, 64'(DEPTH - 7), 64'd0, 64'd0); tick();
    apply(1'b0, 4'h1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    chk("t6_wr", 64'(wr_count), 64'd2);
    chk("t6_rd", 64'(rd_count), 64'd2);
    tick();
    do_reset();
    apply(1'b0, 4'h1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    chk("t6_wr_rst", 64'(wr_count), 64'd0);
    chk("t6_rd_rst", 64'(rd_count), 64'd0);
    tick();
`endif

    do_reset();
    for (int n = 0; n < 1500; n++) begin
      k = $urandom_range(0, 99);
      if (k < 90)      ic = ops[$urandom_range(0, 5)];
      else if (k < 96) ic = 4'($urandom_range(0, 15));
      else             ic = 4'h0;
      v  = ($urandom_range(0, 99) >= 3);
      ie = ($urandom_range(0, 99) < 3);
      r  = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2);
      apply(r, ic, v, ie, rand_addr(), rand_addr(), {$urandom, $urandom});
      if (ic == 4'h4 || ic == 4'h8 || ic == 4'hA) begin
        // random store data, replaced after the check so the model sees it at the edge
        valA = {$urandom, $urandom};
        #1;
        model_eval();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
